// File: rtl/pipe_cg_if.sv
// Handshake/status bundle between the fetch/hazard logic and the pipeline clock-gating controller.
// Latency: none, signal container only.
// Backpressure: fetch_valid/fetch_ready handshake; stall freezes all stages.
// master: fetch/hazard side (drives scan_enable, fetch_valid, stall, flush).
// slave : controller side (drives fetch_ready, stage_en, stage_valid, sleep, gated_cnt).
interface pipe_cg_if #(
   parameter int NSTAGES = 4
);
   logic               scan_enable;
   logic               fetch_valid;
   logic               fetch_ready;
   logic               stall;
   logic               flush;
   logic [NSTAGES-1:0] stage_en;
   logic [NSTAGES-1:0] stage_valid;
   logic               sleep;
   logic [15:0]        gated_cnt;

   modport master (
      output scan_enable, fetch_valid, stall, flush,
      input  fetch_ready, stage_en, stage_valid, sleep, gated_cnt
   );

   modport slave (
      input  scan_enable, fetch_valid, stall, flush,
      output fetch_ready, stage_en, stage_valid, sleep, gated_cnt
   );
endinterface

// File: rtl/pipe_cg_ctrl.sv
// Clock-gating sequencer for an NSTAGES pipeline: tracks stage occupancy, drives per-stage gate enables, sleeps when idle.
// Latency: stage_en/fetch_ready are combinational (zero cycle); stage_valid, state and counters update on the next clk edge.
// Backpressure: fetch_ready drops on stall or outside ACTIVE; stall holds occupancy, flush kills stages 0 and 1.
// Ports: clk, rst_n (async active-low), bus (pipe_cg_if.slave).
// Optional: define PIPE_CG_PERF_EN to build the saturating sleep-cycle counter behind gated_cnt; otherwise it reads 0.
module pipe_cg_ctrl #(
   parameter int NSTAGES     = 4,
   parameter int IDLE_THRESH = 8,
   parameter int WAKE_CYC    = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   pipe_cg_if.slave      bus
);

   localparam logic [1:0] ACTIVE = 2'd0;
   localparam logic [1:0] SLEEP  = 2'd1;
   localparam logic [1:0] WAKE   = 2'd2;

   logic [1:0]         state_q;
   logic [1:0]         state_d;
   logic [7:0]         idle_cnt_q;
   logic [7:0]         idle_cnt_d;
   logic [3:0]         wake_cnt_q;
   logic [3:0]         wake_cnt_d;
   logic [NSTAGES-1:0] v_q;
   logic [NSTAGES-1:0] v_d;
   logic [NSTAGES-1:0] en;
   logic               active;
   logic               ready;
   logic               xfer;
   logic               idle;

   assign active = (state_q == ACTIVE);
   // rst_n is folded in so the fetch side sees no acceptance while reset is held.
   assign ready  = rst_n && active && !bus.stall;
   assign xfer   = bus.fetch_valid && ready;
   assign idle   = !bus.fetch_valid && (v_q == '0);

   // Gate enables go straight to the ICG cells, so they stay combinational.
   always_comb begin
      en    = '0;
      en[0] = xfer && !bus.flush;
      for (int i = 1; i < NSTAGES; i++) begin
         en[i] = active && !bus.stall && v_q[i-1] && !(bus.flush && (i == 1));
      end
      if (!rst_n) begin
         en = '0;
      end
      if (bus.scan_enable) begin
         en = '1;
      end
   end

   // Occupancy: shift unless stalled; flush clears the two front stages on top of that.
   always_comb begin
      v_d = v_q;
      if (!bus.stall) begin
         v_d[0] = xfer;
         for (int i = 1; i < NSTAGES; i++) begin
            v_d[i] = v_q[i-1];
         end
      end
      if (bus.flush) begin
         v_d[0] = 1'b0;
         v_d[1] = 1'b0;
      end
   end

   always_comb begin
      state_d    = state_q;
      idle_cnt_d = '0;
      wake_cnt_d = '0;
      case (state_q)
         ACTIVE: begin
            if (idle) begin
               if (idle_cnt_q == 8'(IDLE_THRESH - 1)) begin
                  state_d = SLEEP;
               end else begin
                  idle_cnt_d = idle_cnt_q + 8'd1;
               end
            end
         end
         SLEEP: begin
            if (bus.fetch_valid) begin
               state_d = WAKE;
            end
         end
         WAKE: begin
            // Counter starts at 0 on entry, so WAKE lasts exactly WAKE_CYC cycles.
            if (wake_cnt_q == 4'(WAKE_CYC - 1)) begin
               state_d = ACTIVE;
            end else begin
               wake_cnt_d = wake_cnt_q + 4'd1;
            end
         end
         default: state_d = ACTIVE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ACTIVE;
         idle_cnt_q <= '0;
         wake_cnt_q <= '0;
         v_q        <= '0;
      end else begin
         state_q    <= state_d;
         idle_cnt_q <= idle_cnt_d;
         wake_cnt_q <= wake_cnt_d;
         v_q        <= v_d;
      end
   end

`ifdef PIPE_CG_PERF_EN
   logic [15:0] gated_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gated_q <= '0;
      end else if ((state_q == SLEEP) && (gated_q != 16'hFFFF)) begin
         gated_q <= gated_q + 16'd1;
      end
   end

   assign bus.gated_cnt = gated_q;
`else
   assign bus.gated_cnt = 16'h0000;
`endif

   assign bus.fetch_ready = ready;
   assign bus.stage_en    = en;
   assign bus.stage_valid = v_q;
   assign bus.sleep       = (state_q == SLEEP);

endmodule

// File: doc/pipe_cg_ctrl.md
PIPE_CG_CTRL -- requirements
Module: pipe_cg_ctrl

Interface
REQ-001 Parameter NSTAGES, default 4, number of clock-gated pipeline stages sequenced (2..8).
REQ-002 Parameter IDLE_THRESH, default 8, consecutive empty cycles before entering sleep (2..255).
REQ-003 Parameter WAKE_CYC, default 2, wake-up settle cycles before accepting work (1..15).
REQ-004 clk  input  1  single clock for all state.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 scan_enable  input  1  test-mode override, forces every stage clock on.
REQ-007 fetch_valid  input  1  new instruction offered to stage 0.
REQ-008 fetch_ready  output  1  stage 0 accepts the instruction this cycle.
REQ-009 stall  input  1  hazard-unit stall, freezes all stages.
REQ-010 flush  input  1  branch redirect, kills stages 0 and 1.
REQ-011 stage_en  output  NSTAGES  per-stage enable to the stage's clock-gating cell.
REQ-012 stage_valid  output  NSTAGES  registered occupancy bit per stage.
REQ-013 sleep  output  1  controller is in SLEEP.
REQ-014 gated_cnt  output  16  count of sleep cycles (see Configuration).

Function
REQ-015 FSM states SHALL be ACTIVE, SLEEP and WAKE; reset state is ACTIVE.
REQ-016 fetch_ready SHALL be 1 only when state==ACTIVE and stall==0; a transfer occurs when fetch_valid and fetch_ready are both 1.
REQ-017 Without stall or flush, stage_valid SHALL shift each cycle: v[0]<=transfer, v[i]<=v[i-1]; v[NSTAGES-1] retires.
REQ-018 With stall=1 and flush=0, stage_valid SHALL hold its value.
REQ-019 With flush=1, v[0] and v[1] SHALL clear next cycle regardless of stall, a same-cycle transfer SHALL be dropped, and v[2..] SHALL follow REQ-017/018.
REQ-020 stage_en[0] SHALL equal transfer && !flush; stage_en[i], i>0, SHALL equal (state==ACTIVE) && !stall && v[i-1] && !(flush && i==1).
REQ-021 stage_en SHALL be combinational from registered state and current inputs, with zero-cycle latency to the gating cell.
REQ-022 scan_enable=1 SHALL force stage_en to all ones; FSM, counters and stage_valid SHALL keep their normal behaviour.
REQ-023 In ACTIVE, an 8-bit idle counter SHALL increment when fetch_valid==0 and stage_valid==0, and clear otherwise.
REQ-024 When the idle counter equals IDLE_THRESH-1 and the idle condition still holds, the FSM SHALL go to SLEEP next cycle and the counter SHALL clear.
REQ-025 In SLEEP, sleep SHALL be 1, stage_en SHALL be 0 (unless scan_enable), and fetch_valid=1 SHALL move the FSM to WAKE next cycle.
REQ-026 In WAKE, a 4-bit counter SHALL run for exactly WAKE_CYC cycles, then the FSM SHALL go to ACTIVE; fetch_ready SHALL be 0 throughout.
REQ-027 flush and stall SHALL have no effect on FSM transitions in SLEEP or WAKE.
REQ-028 Asserting rst_n low in any state SHALL immediately return the FSM to ACTIVE and clear all counters and stage_valid.

Reset
REQ-029 While rst_n=0: state=ACTIVE, stage_valid=0, idle and wake counters=0, gated_cnt=0, sleep=0.
REQ-030 While rst_n=0: fetch_ready=0 and stage_en=0, except all ones when scan_enable=1.

Configuration
REQ-031 With macro PIPE_CG_PERF_EN defined, gated_cnt SHALL increment once per cycle with sleep=1 and saturate at 16'hFFFF.
REQ-032 Without PIPE_CG_PERF_EN, gated_cnt SHALL be tied to 16'h0000 and no counter flops SHALL be synthesised; all other behaviour SHALL be identical.

Verification
REQ-033 Reset, then fetch_valid=1 for 3 cycles -> stage_valid steps 0001, 0011, 0111, 1110, 1100, 1000, 0000.
REQ-034 Pipeline 0111, stall=1 for 2 cycles -> stage_valid holds 0111, stage_en=0000, fetch_ready=0; resumes shifting after stall drops.
REQ-035 Pipeline 0111, flush=1 together with stall=1 -> next stage_valid=0100; stage_en[1]=0 in the flush cycle.
REQ-036 Empty pipeline, fetch_valid=0 -> sleep=1 after exactly 8 cycles; fetch_valid=1 -> WAKE for 2 cycles, then fetch_ready=1.
REQ-037 In SLEEP, scan_enable=1 -> stage_en=1111 and sleep stays 1; rst_n pulsed low in WAKE -> state ACTIVE and fetch_ready=1 on the first cycle after release.
REQ-038 With PIPE_CG_PERF_EN, 20 sleep cycles -> gated_cnt=20; preloaded at 16'hFFFE, 5 more sleep cycles -> 16'hFFFF; without the macro gated_cnt=0 throughout.
